vga_layer_mixer: RTL and testbench

- Parametrised successor to the single-player/single-exit frame renderer.
- Composites a tiled maze background with NUM_SPRITES tile-aligned sprites under a fixed priority, with colour-key transparency and per-sprite blink.
- Sprite positions are double-buffered and latched only at frame start, so frames never tear; a per-frame sprite collision flag is also produced.
- Sits between the VGA timing generator and the DAC pins; drives external 1-cycle-latency ROMs.

---
 rtl/vga_layer_mixer.sv | 160 ++++++++++++++++
 tb/tb_vga_layer_mixer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_mixer.sv
// rtl/vga_layer_mixer.sv - maze background plus prioritised, colour-keyed, blinking sprites
module vga_layer_mixer #(
    parameter int          TILE_LOG2      = 4,
    parameter int          MAZE_COLS_LOG2 = 6,
    parameter int          MAZE_ROWS_LOG2 = 5,
    parameter int          NUM_SPRITES    = 2,
    parameter logic [11:0] TRANSP_KEY     = 12'hF0F,
    parameter int          BLINK_BIT      = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_pix_valid,
    input  logic [9:0]                                  i_col,
    input  logic [9:0]                                  i_row,
    input  logic                                        i_frame_start,
    input  logic [NUM_SPRITES*(10-TILE_LOG2)-1:0]       i_spr_bcol,
    input  logic [NUM_SPRITES*(10-TILE_LOG2)-1:0]       i_spr_brow,
    input  logic [NUM_SPRITES-1:0]                      i_spr_en,
    input  logic [NUM_SPRITES-1:0]                      i_blink_mask,
    output logic [MAZE_COLS_LOG2+MAZE_ROWS_LOG2-1:0]    o_maze_addr,
    input  logic [15:0]                                 i_maze_data,
    output logic [2*TILE_LOG2-1:0]                      o_spr_addr,
    input  logic [NUM_SPRITES*16-1:0]                   i_spr_data,
    output logic                                        o_rom_en,
    output logic                                        o_pix_valid,
    output logic [3:0]                                  o_red,
    output logic [3:0]                                  o_green,
    output logic [3:0]                                  o_blue,
    output logic                                        o_collision,
    output logic [7:0]                                  o_frame_cnt
);

    localparam int TW  = 10 - TILE_LOG2;
    localparam int AW  = MAZE_COLS_LOG2 + MAZE_ROWS_LOG2;
    localparam int SPW = NUM_SPRITES * TW;

    logic [AW-1:0]          tile_col_w;
    logic [AW-1:0]          tile_row_w;

    logic                   s1_valid_q;
    logic [TW-1:0]          s1_tcol_q;
    logic [TW-1:0]          s1_trow_q;

    logic [SPW-1:0]         sh_bcol_q;
    logic [SPW-1:0]         sh_brow_q;
    logic [NUM_SPRITES-1:0] sh_en_q;
    logic [NUM_SPRITES-1:0] sh_blink_q;

    logic [7:0]             frame_cnt_q;
    logic                   sticky_q;
    logic                   collision_q;

    logic [NUM_SPRITES-1:0] vis;
    logic [11:0]            rgb_d;
    logic                   collide_now;

    logic [11:0]            rgb_q;
    logic                   pix_valid_q;

    logic [4*NUM_SPRITES+3:0] unused_hi;

    // ROM addresses come straight from the incoming coordinates; out-of-maze tiles wrap by truncation
    assign tile_col_w  = AW'(i_col >> TILE_LOG2);
    assign tile_row_w  = AW'(i_row >> TILE_LOG2);
    assign o_maze_addr = (tile_row_w << MAZE_COLS_LOG2) | tile_col_w;
    assign o_spr_addr  = {i_col[TILE_LOG2-1:0], i_row[TILE_LOG2-1:0]};
    assign o_rom_en    = i_pix_valid;

    // Stage 1: hold tile coordinates and valid while the ROM data is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_tcol_q  <= '0;
            s1_trow_q  <= '0;
        end else begin
            s1_valid_q <= i_pix_valid;
            s1_tcol_q  <= i_col[9:TILE_LOG2];
            s1_trow_q  <= i_row[9:TILE_LOG2];
        end
    end

    // Sprite state is only taken at frame start so a frame never shows a half-moved sprite
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_bcol_q  <= '0;
            sh_brow_q  <= '0;
            sh_en_q    <= '0;
            sh_blink_q <= '0;
        end else if (i_frame_start) begin
            sh_bcol_q  <= i_spr_bcol;
            sh_brow_q  <= i_spr_brow;
            sh_en_q    <= i_spr_en;
            sh_blink_q <= i_blink_mask;
        end
    end

    // Layer mix: walk from lowest to highest priority so the lowest visible index wins
    always_comb begin
        vis   = '0;
        rgb_d = i_maze_data[11:0];
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            vis[k] = sh_en_q[k]
                   & ~(sh_blink_q[k] & frame_cnt_q[BLINK_BIT])
                   & (sh_bcol_q[k*TW +: TW] == s1_tcol_q)
                   & (sh_brow_q[k*TW +: TW] == s1_trow_q)
                   & (i_spr_data[k*16 +: 12] != TRANSP_KEY);
            if (vis[k]) begin
                rgb_d = i_spr_data[k*16 +: 12];
            end
        end
        if (!s1_valid_q) begin
            rgb_d = '0;
        end
    end

    // Two or more set bits in vis means sprites overlap on this pixel
    assign collide_now = s1_valid_q & (|(vis & (vis - NUM_SPRITES'(1))));

    // Frame counter and collision: the frame-start cycle's own event still reaches the report
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            sticky_q    <= 1'b0;
            collision_q <= 1'b0;
        end else if (i_frame_start) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            collision_q <= sticky_q | collide_now;
            sticky_q    <= 1'b0;
        end else if (collide_now) begin
            sticky_q    <= 1'b1;
        end
    end

    // Stage 2: register the mixed colour and its valid for the DAC
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q       <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            pix_valid_q <= s1_valid_q;
        end
    end

    // ROM data bits above RGB carry nothing this block uses
    always_comb begin
        unused_hi[3:0] = i_maze_data[15:12];
        for (int k = 0; k < NUM_SPRITES; k++) begin
            unused_hi[4+4*k +: 4] = i_spr_data[16*k+12 +: 4];
        end
    end

    assign o_pix_valid = pix_valid_q;
    assign o_red       = rgb_q[11:8];
    assign o_green     = rgb_q[7:4];
    assign o_blue      = rgb_q[3:0];
    assign o_collision = collision_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// tb/tb_vga_layer_mixer.sv - scoreboard bench for vga_layer_mixer
module tb_vga_layer_mixer;

    logic        clk;
    logic        rst;
    logic        pix_valid;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        frame_start;
    logic [11:0] spr_bcol;
    logic [11:0] spr_brow;
    logic [1:0]  spr_en;
    logic [1:0]  blink_mask;
    logic [10:0] maze_addr;
    logic [15:0] maze_data;
    logic [7:0]  spr_addr;
    logic [31:0] spr_data;
    logic        rom_en;
    logic        pv_o;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        collision;
    logic [7:0]  frame_cnt;

    logic [11:0] spr_v0;
    logic [11:0] spr_v1;

    logic [5:0]  m_bcol [2];
    logic [5:0]  m_brow [2];
    logic [1:0]  m_en;
    logic [1:0]  m_blink;
    logic [7:0]  m_cnt;
    logic        m_sticky;
    logic        m_coll;
    logic        m_pending;
    logic [12:0] exp_q [$];

    int total;
    int bad;

    vga_layer_mixer dut (
        .clk          (clk),
        .rst          (rst),
        .i_pix_valid  (pix_valid),
        .i_col        (col),
        .i_row        (row),
        .i_frame_start(frame_start),
        .i_spr_bcol   (spr_bcol),
        .i_spr_brow   (spr_brow),
        .i_spr_en     (spr_en),
        .i_blink_mask (blink_mask),
        .o_maze_addr  (maze_addr),
        .i_maze_data  (maze_data),
        .o_spr_addr   (spr_addr),
        .i_spr_data   (spr_data),
        .o_rom_en     (rom_en),
        .o_pix_valid  (pv_o),
        .o_red        (red),
        .o_green      (green),
        .o_blue       (blue),
        .o_collision  (collision),
        .o_frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ROMs, one-cycle latency
    always @(posedge clk) begin
        if (rom_en) maze_data <= {4'hC, 1'b0, maze_addr ^ 11'h5A3};
        spr_data <= {4'hA, spr_v1, 4'h5, spr_v0};
    end

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_bcol[k] = '0;
            m_brow[k] = '0;
        end
        m_en = '0; m_blink = '0; m_cnt = '0;
        m_sticky = 1'b0; m_coll = 1'b0; m_pending = 1'b0;
        exp_q.delete();
        exp_q.push_back(13'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0;
        model_clear();
        @(posedge clk); #1;
        total++;
        if (pv_o !== 1'b0) begin bad++; $display("FAIL rst_pix_valid got=%0b want=0", pv_o); end
        total++;
        if ({red, green, blue} !== 12'h000) begin bad++; $display("FAIL rst_rgb got=%h want=000", {red, green, blue}); end
        total++;
        if (frame_cnt !== 8'd0) begin bad++; $display("FAIL rst_frame_cnt got=%0d want=0", frame_cnt); end
        total++;
        if (collision !== 1'b0) begin bad++; $display("FAIL rst_collision got=%0b want=0", collision); end
        rst = 1'b0;
    endtask

    task automatic step(input logic v, input int c, input int r, input logic fs);
        logic [11:0] sv [2];
        logic [11:0] rgb;
        logic [10:0] addr;
        logic [7:0]  saddr;
        logic [12:0] exp_v;
        logic [12:0] got;
        int nvis;
        @(negedge clk);
        pix_valid = v; col = 10'(c); row = 10'(r); frame_start = fs;
        if (fs) begin
            m_coll = m_sticky | m_pending;
            m_sticky = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_bcol[k] = spr_bcol[k*6 +: 6];
                m_brow[k] = spr_brow[k*6 +: 6];
            end
            m_en = spr_en; m_blink = blink_mask; m_cnt = m_cnt + 8'd1;
        end else begin
            m_sticky = m_sticky | m_pending;
        end
        sv[0] = spr_v0; sv[1] = spr_v1;
        addr  = 11'(((r >> 4) << 6) | (c >> 4));
        saddr = 8'(((c & 15) << 4) | (r & 15));
        rgb   = {1'b0, addr} ^ 12'h5A3;
        nvis  = 0;
        for (int k = 1; k >= 0; k--) begin
            if (m_en[k] && !(m_blink[k] && m_cnt[4]) && (m_bcol[k] == 6'(c >> 4))
                && (m_brow[k] == 6'(r >> 4)) && (sv[k] != 12'hF0F)) begin
                rgb = sv[k];
                nvis++;
            end
        end
        m_pending = v && (nvis >= 2);
        exp_v = v ? {1'b1, rgb} : 13'd0;
        exp_q.push_back(exp_v);
        #1;
        total++;
        if (maze_addr !== addr || spr_addr !== saddr || rom_en !== v) begin
            bad++;
            $display("FAIL rom_addr got=%h/%h/%b want=%h/%h/%b", maze_addr, spr_addr, rom_en, addr, saddr, v);
        end
        @(posedge clk); #1;
        got = {pv_o, red, green, blue};
        total++;
        if (exp_q.size() == 0) begin
            bad++; $display("FAIL pixel_out got=%h want=<queue empty>", got);
        end else begin
            exp_v = exp_q.pop_front();
            if (got !== exp_v) begin bad++; $display("FAIL pixel_out got=%h want=%h", got, exp_v); end
        end
        total++;
        if (frame_cnt !== m_cnt) begin bad++; $display("FAIL frame_cnt got=%0d want=%0d", frame_cnt, m_cnt); end
        total++;
        if (collision !== m_coll) begin bad++; $display("FAIL collision got=%0b want=%0b", collision, m_coll); end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_maze_pixel();
        logic [10:0] a;
        logic [7:0]  s;
        step(1'b1, 37, 18, 1'b0);
        a = maze_addr; s = spr_addr;
        total++;
        if (a !== 11'h042) begin bad++; $display("FAIL maze_addr_37_18 got=%h want=042", a); end
        total++;
        if (s !== 8'h52) begin bad++; $display("FAIL spr_addr_37_18 got=%h want=52", s); end
        step(1'b0, 0, 0, 1'b0);
        total++;
        if ({pv_o, red, green, blue} !== 13'h15E1) begin
            bad++; $display("FAIL maze_latency got=%h want=15e1", {pv_o, red, green, blue});
        end
        step(1'b1, 700, 500, 1'b0);
        step(1'b1, 1023, 479, 1'b0);
        step(1'b0, 5, 5, 1'b0);
        step(1'b1, 15, 15, 1'b0);
        step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_priority_collision();
        spr_bcol = {6'd2, 6'd2}; spr_brow = {6'd1, 6'd1};
        spr_en = 2'b11; blink_mask = 2'b00;
        spr_v0 = 12'hF00; spr_v1 = 12'h00F;
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 32, 16, 1'b0);
        step(1'b1, 47, 31, 1'b0);
        step(1'b1, 40, 20, 1'b0);
        step(1'b1, 48, 20, 1'b0);
        total++;
        if ({red, green, blue} !== 12'hF00) begin bad++; $display("FAIL priority_red got=%h want=f00", {red, green, blue}); end
        step(1'b0, 0, 0, 1'b0);
        spr_bcol = {6'd5, 6'd2};
        step(1'b0, 0, 0, 1'b1);
        total++;
        if (collision !== 1'b1) begin bad++; $display("FAIL collision_set got=%0b want=1", collision); end
        step(1'b1, 40, 20, 1'b0);
        step(1'b1, 36, 24, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        total++;
        if (collision !== 1'b0) begin bad++; $display("FAIL collision_clear got=%0b want=0", collision); end
    endtask

    task automatic test_transparency();
        spr_bcol = {6'd2, 6'd2}; spr_brow = {6'd1, 6'd1}; spr_en = 2'b11;
        spr_v0 = 12'hF0F; spr_v1 = 12'h0F0;
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 33, 17, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        total++;
        if ({red, green, blue} !== 12'h0F0) begin bad++; $display("FAIL key_fallthrough got=%h want=0f0", {red, green, blue}); end
        spr_en = 2'b01;
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 33, 17, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        total++;
        if ({red, green, blue} !== 12'h5E1) begin bad++; $display("FAIL key_to_maze got=%h want=5e1", {red, green, blue}); end
    endtask

    task automatic test_shadow();
        spr_bcol = {6'd5, 6'd2}; spr_brow = {6'd1, 6'd1}; spr_en = 2'b11;
        spr_v0 = 12'hF00; spr_v1 = 12'h00F;
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 34, 18, 1'b0);
        spr_bcol = {6'd5, 6'd7};
        step(1'b1, 34, 18, 1'b0);
        step(1'b1, 120, 18, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        total++;
        if ({red, green, blue} !== 12'h5E4) begin bad++; $display("FAIL shadow_hold got=%h want=5e4", {red, green, blue}); end
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 120, 18, 1'b0);
        step(1'b1, 34, 18, 1'b0);
        step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_blink_wrap();
        logic [7:0]  cnt;
        logic [11:0] want;
        do_reset();
        spr_bcol = {6'd9, 6'd2}; spr_brow = {6'd9, 6'd1};
        spr_en = 2'b01; blink_mask = 2'b01; spr_v0 = 12'hF00;
        for (int i = 1; i <= 260; i++) begin
            step(1'b0, 0, 0, 1'b1);
            step(1'b1, 40, 20, 1'b0);
            step(1'b0, 0, 0, 1'b0);
            cnt  = 8'(i);
            want = (cnt[4] == 1'b0) ? 12'hF00 : 12'h5E1;
            total++;
            if ({red, green, blue} !== want) begin
                bad++; $display("FAIL blink cnt=%0d got=%h want=%h", cnt, {red, green, blue}, want);
            end
            if (i == 256) begin
                total++;
                if (frame_cnt !== 8'd0) begin bad++; $display("FAIL frame_wrap got=%0d want=0", frame_cnt); end
            end
        end
        blink_mask = 2'b00;
    endtask

    task automatic test_reset_mid();
        spr_bcol = {6'd5, 6'd2}; spr_brow = {6'd1, 6'd1}; spr_en = 2'b01;
        spr_v0 = 12'hF00;
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 40, 20, 1'b0);
        step(1'b1, 40, 20, 1'b0);
        do_reset();
        step(1'b1, 40, 20, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        total++;
        if ({red, green, blue} !== 12'h5E1) begin bad++; $display("FAIL post_reset_no_sprite got=%h want=5e1", {red, green, blue}); end
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 40, 20, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        total++;
        if ({red, green, blue} !== 12'hF00) begin bad++; $display("FAIL post_reset_sprite got=%h want=f00", {red, green, blue}); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                spr_bcol   = {6'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
                spr_brow   = {6'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
                spr_en     = 2'($urandom_range(0, 3));
                blink_mask = 2'($urandom_range(0, 3));
            end
            spr_v0 = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
            spr_v1 = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
            step(($urandom_range(0, 4) != 0), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                 ($urandom_range(0, 19) == 0));
        end
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; pix_valid = 1'b0; col = '0; row = '0; frame_start = 1'b0;
        spr_bcol = '0; spr_brow = '0; spr_en = '0; blink_mask = '0;
        spr_v0 = '0; spr_v1 = '0;
        maze_data = '0; spr_data = '0;
        test_reset();
        test_maze_pixel();
        test_priority_collision();
        test_transparency();
        test_shadow();
        test_blink_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
